keypoint_scan_writer: RTL and testbench

Parametrised keypoint scan-and-store engine for the DoG detection stage. Each row it accepts one candidate bitmap per DoG channel from the detector and walks the set bits lowest-column-first. It presents each candidate column to the external contrast/edge filter and writes the passing {row, col} coordinates into per-channel keypoint SRAMs. Generalises the two-channel fixed-width controller to N_CH channels, arbitrary row width and memory depth, with per-row handshake, sticky overflow detection and keypoint counts.

---
 rtl/keypoint_scan_writer.sv | 148 ++++++++++++++
 tb/tb_keypoint_scan_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_scan_writer.sv
// rtl/keypoint_scan_writer.sv - DoG keypoint scan-and-store engine
// Walks per-channel candidate masks lowest column first and writes filtered {row, col} keypoints.
module keypoint_scan_writer #(
  parameter int COLS    = 638,
  parameter int ROWS    = 480,
  parameter int N_CH    = 2,
  parameter int COL_OFS = 1,
  parameter int ROW_W   = 9,
  parameter int COL_W   = 10,
  parameter int ADDR_W  = 11
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic                             row_valid,
  output logic                             row_ready,
  input  logic [N_CH*COLS-1:0]             row_mask,
  output logic [N_CH-1:0]                  cand_valid,
  output logic [N_CH*COL_W-1:0]            cand_col,
  input  logic [N_CH-1:0]                  cand_pass,
  output logic [N_CH-1:0]                  kp_we,
  output logic [N_CH*ADDR_W-1:0]           kp_addr,
  output logic [N_CH*(ROW_W+COL_W)-1:0]    kp_din,
  output logic [N_CH*(ADDR_W+1)-1:0]       kp_count,
  output logic [N_CH-1:0]                  kp_ovf
);

  localparam int KP_W  = ROW_W + COL_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(1 << ADDR_W);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [N_CH*COLS-1:0]     mask_q, mask_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [N_CH*CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]          ovf_q, ovf_d;
  logic [N_CH-1:0]          we_q, we_d;
  logic [N_CH*ADDR_W-1:0]   addr_q, addr_d;
  logic [N_CH*KP_W-1:0]     din_q, din_d;
  logic                     scan_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (row_valid) state_d = S_SCAN;
      S_SCAN: if (scan_empty) state_d = (row_q == LAST_ROW) ? S_DONE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    row_ready = (state_q == S_LOAD);
  end

  // Priority search runs high to low so the lowest set bit wins.
  always_comb begin
    cand_valid = '0;
    cand_col   = '0;
    for (int c = 0; c < N_CH; c++) begin
      cand_valid[c] = |mask_q[c*COLS +: COLS];
      for (int i = COLS - 1; i >= 0; i--) begin
        if (mask_q[c*COLS + i]) cand_col[c*COL_W +: COL_W] = COL_W'(i + COL_OFS);
      end
    end
  end

  assign scan_empty = ~|cand_valid;

  always_comb begin
    logic [COLS-1:0] m;
    m      = '0;
    mask_d = mask_q;
    row_d  = row_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    we_d   = '0;
    addr_d = addr_q;
    din_d  = din_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d = '0;
          cnt_d = '0;
          ovf_d = '0;
        end
      end
      S_LOAD: if (row_valid) mask_d = row_mask;
      S_SCAN: begin
        for (int c = 0; c < N_CH; c++) begin
          m = mask_q[c*COLS +: COLS];
          mask_d[c*COLS +: COLS] = m & (m - COLS'(1));
          if (cand_valid[c] && cand_pass[c]) begin
            if (cnt_q[c*CNT_W +: CNT_W] < DEPTH) begin
              we_d[c]                    = 1'b1;
              addr_d[c*ADDR_W +: ADDR_W] = cnt_q[c*CNT_W +: ADDR_W];
              din_d[c*KP_W +: KP_W]      = {row_q, cand_col[c*COL_W +: COL_W]};
              cnt_d[c*CNT_W +: CNT_W]    = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
            end else begin
              ovf_d[c] = 1'b1;
            end
          end
        end
        if (scan_empty && row_q != LAST_ROW) row_d = row_q + ROW_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      row_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      mask_q <= mask_d;
      row_q  <= row_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign kp_we    = we_q;
  assign kp_addr  = addr_q;
  assign kp_din   = din_q;
  assign kp_count = cnt_q;
  assign kp_ovf   = ovf_q;

endmodule

// File: tb/tb_keypoint_scan_writer.sv
// tb/tb_keypoint_scan_writer.sv - self-checking bench for keypoint_scan_writer
// Frame vectors from a table; keypoint writes checked against a per-channel scoreboard.
module tb_keypoint_scan_writer;

  localparam int COLS    = 638;
  localparam int ROWS    = 4;
  localparam int N_CH    = 2;
  localparam int COL_OFS = 1;
  localparam int ROW_W   = 9;
  localparam int COL_W   = 10;
  localparam int ADDR_W  = 2;
  localparam int KP_W    = ROW_W + COL_W;
  localparam int CNT_W   = ADDR_W + 1;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NONE    = 1023;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       row_valid;
  logic                       row_ready;
  logic [N_CH*COLS-1:0]       row_mask;
  logic [N_CH-1:0]            cand_valid;
  logic [N_CH*COL_W-1:0]      cand_col;
  logic [N_CH-1:0]            cand_pass;
  logic [N_CH-1:0]            kp_we;
  logic [N_CH*ADDR_W-1:0]     kp_addr;
  logic [N_CH*KP_W-1:0]       kp_din;
  logic [N_CH*CNT_W-1:0]      kp_count;
  logic [N_CH-1:0]            kp_ovf;

  keypoint_scan_writer #(
    .COLS(COLS), .ROWS(ROWS), .N_CH(N_CH), .COL_OFS(COL_OFS),
    .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .row_valid(row_valid), .row_ready(row_ready), .row_mask(row_mask),
    .cand_valid(cand_valid), .cand_col(cand_col), .cand_pass(cand_pass),
    .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din),
    .kp_count(kp_count), .kp_ovf(kp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter model: rejects one chosen column per channel.
  logic [COL_W-1:0] rej0, rej1;
  always_comb begin
    cand_pass[0] = (cand_col[0 +: COL_W] != rej0);
    cand_pass[1] = (cand_col[COL_W +: COL_W] != rej1);
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [KP_W-1:0]   d;
  } wr_t;

  typedef struct {
    int               row;
    logic [COLS-1:0]  m0;
    logic [COLS-1:0]  m1;
    logic [COL_W-1:0] rej0;
    logic [COL_W-1:0] rej1;
    int               exp_len;
    int               exp_scan;
    int               exp_v1;
    logic [CNT_W-1:0] exp_c0;
    logic [CNT_W-1:0] exp_c1;
    logic [N_CH-1:0]  exp_ovf;
  } vec_t;

  wr_t  sbq[N_CH][$];
  int   mcnt[N_CH];
  int   total;
  int   bad;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int row, input int r0, input int r1, input int len,
                              input int scan, input int v1, input int c0, input int c1,
                              input int ovf);
    vec_t v;
    v.row = row;
    v.m0 = '0;
    v.m1 = '0;
    v.rej0 = COL_W'(r0);
    v.rej1 = COL_W'(r1);
    v.exp_len = len;
    v.exp_scan = scan;
    v.exp_v1 = v1;
    v.exp_c0 = CNT_W'(c0);
    v.exp_c1 = CNT_W'(c1);
    v.exp_ovf = N_CH'(ovf);
    return v;
  endfunction

  task automatic push_row(input int r, input int c, input logic [COLS-1:0] m,
                          input logic [COL_W-1:0] rej);
    logic [COL_W-1:0] col;
    wr_t w;
    for (int i = 0; i < COLS; i++) begin
      if (m[i]) begin
        col = COL_W'(i + COL_OFS);
        if (col != rej && mcnt[c] < DEPTH) begin
          w.a = ADDR_W'(mcnt[c]);
          w.d = {ROW_W'(r), col};
          sbq[c].push_back(w);
          mcnt[c]++;
        end
      end
    end
  endtask

  task automatic mon_writes();
    wr_t w;
    for (int c = 0; c < N_CH; c++) begin
      if (kp_we[c]) begin
        if (sbq[c].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write ch%0d: got addr %0h din %0h, expected no write",
                   c, kp_addr[c*ADDR_W +: ADDR_W], kp_din[c*KP_W +: KP_W]);
        end else begin
          w = sbq[c].pop_front();
          chk($sformatf("wr_addr_ch%0d", c), 64'(kp_addr[c*ADDR_W +: ADDR_W]), 64'(w.a));
          chk($sformatf("wr_din_ch%0d", c), 64'(kp_din[c*KP_W +: KP_W]), 64'(w.d));
        end
      end
    end
  endtask

  task automatic run_frame(input int vi);
    vec_t v;
    int   j, ld, scan, vc1;
    bit   seen;
    v = vecs[vi];
    rej0 = v.rej0;
    rej1 = v.rej1;
    for (int c = 0; c < N_CH; c++) mcnt[c] = 0;
    ld = 0; scan = 0; vc1 = 0; j = 0; seen = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk($sformatf("v%0d_cleared", vi), 64'({kp_count, kp_ovf}), 64'(0));
    while (!seen && j < 200) begin
      mon_writes();
      if (row_ready) begin
        if (ld == v.row) begin
          row_mask = {v.m1, v.m0};
          push_row(ld, 0, v.m0, v.rej0);
          push_row(ld, 1, v.m1, v.rej1);
        end else begin
          row_mask = '0;
        end
        ld++;
      end else if (busy && !done && ld - 1 == v.row) begin
        scan++;
        if (cand_valid[1]) vc1++;
      end
      if (done) seen = 1'b1;
      else begin
        j++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL v%0d_timeout: got no done after %0d cycles, expected done", vi, j);
    end
    chk($sformatf("v%0d_frame_len", vi), 64'(j), 64'(v.exp_len));
    chk($sformatf("v%0d_scan_cycles", vi), 64'(scan), 64'(v.exp_scan));
    chk($sformatf("v%0d_ch1_valid_cycles", vi), 64'(vc1), 64'(v.exp_v1));
    chk($sformatf("v%0d_kp_count", vi), 64'(kp_count), 64'({v.exp_c1, v.exp_c0}));
    chk($sformatf("v%0d_kp_ovf", vi), 64'(kp_ovf), 64'(v.exp_ovf));
    @(negedge clk);
    mon_writes();
    chk($sformatf("v%0d_post_done", vi), 64'({busy, done}), 64'(0));
    chk($sformatf("v%0d_sb_empty", vi), 64'(sbq[0].size() + sbq[1].size()), 64'(0));
    row_mask = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    row_valid = 1'b1;
    row_mask = '0;
    rej0 = COL_W'(NONE);
    rej1 = COL_W'(NONE);

    vecs[0] = mk(0, NONE, NONE, 8, 1, 0, 0, 0, 0);
    vecs[1] = mk(2, NONE, NONE, 9, 2, 0, 1, 0, 0);
    vecs[1].m0[5] = 1'b1;
    vecs[2] = mk(1, NONE, 4, 11, 4, 3, 0, 2, 0);
    vecs[2].m1[0] = 1'b1;
    vecs[2].m1[3] = 1'b1;
    vecs[2].m1[637] = 1'b1;
    vecs[3] = mk(3, 11, NONE, 13, 6, 1, 4, 1, 0);
    vecs[3].m0[1] = 1'b1;
    vecs[3].m0[2] = 1'b1;
    vecs[3].m0[10] = 1'b1;
    vecs[3].m0[20] = 1'b1;
    vecs[3].m0[30] = 1'b1;
    vecs[3].m1[7] = 1'b1;
    vecs[4] = mk(0, NONE, NONE, 14, 7, 0, 4, 0, 1);
    for (int i = 0; i < 6; i++) vecs[4].m0[i] = 1'b1;
    vecs[5] = mk(3, NONE, NONE, 9, 2, 1, 1, 1, 0);
    vecs[5].m0[637] = 1'b1;
    vecs[5].m1[0] = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, row_ready, kp_we, kp_addr, kp_din, kp_count, kp_ovf, cand_valid}), 64'(0));
    rst_n = 1'b1;

    // Stall in LOAD, then reset in the middle of a SCAN.
    row_valid = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", 64'({row_ready, busy, cand_valid}), 64'({1'b1, 1'b1, 2'b00}));
      @(negedge clk);
    end
    row_mask = '0;
    row_mask[3] = 1'b1;
    row_mask[4] = 1'b1;
    row_valid = 1'b1;
    @(negedge clk);
    chk("scan_entered", 64'({busy, row_ready, cand_valid}), 64'({1'b1, 1'b0, 2'b01}));
    chk("scan_col", 64'(cand_col[0 +: COL_W]), 64'(4));
    #1 rst_n = 1'b0;
    #1 chk("midframe_reset", 64'({busy, done, row_ready, kp_we, kp_addr, kp_din, kp_count, kp_ovf, cand_valid}), 64'(0));
    row_mask = '0;
    @(negedge clk) rst_n = 1'b1;

    for (int vi = 0; vi < 6; vi++) run_frame(vi);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
